// File: rtl/ram_16x8.sv
// ram_16x8 -- single-port synchronous scratch RAM, 16 words x 8 bits, on a
// shared bidirectional data bus.
//
// The operation is decoded from {we, enable} on every rising clk edge:
//   10 write : mem[addr] <= data (host drives the bus)
//   01 read  : rd_q <= mem[addr]; the word is driven on the bus after the edge
//   00 idle  : nothing stored, bus released
//   11 treated as idle (no write, no drive, array and read register untouched)
// Read latency is one cycle. The bus drive is additionally gated by the
// *current* enable/we, so the RAM lets go of the bus the moment enable falls
// or we rises, without waiting for a clock edge.
//
// Optional feature macro: RAM_CLEAR_ON_RESET_EN
//   defined   : a reset cycle also zeroes every array word
//   undefined : reset touches only the read register; the array keeps its
//               contents and has no reset, so it can map onto plain RAM
//
// Ports:
//   clk    in     rising-edge clock
//   rst    in     synchronous, active-high reset (wins over read and write)
//   data   inout  DATA_WIDTH bidirectional data bus
//   we     in     write enable, active high
//   enable in     read / output enable, active high
//   addr   in     ADDR_WIDTH word address (full decode, every value valid)

module ram_16x8 #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  we,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] addr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_READ    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    op_e                   op;
    logic                  do_wr;
    logic                  do_rd;
    logic                  bus_oe;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rd_vld;

    assign op    = op_e'({we, enable});
    // OP_ILLEGAL and OP_IDLE both fall through to "do nothing".
    assign do_wr = (op == OP_WRITE);
    assign do_rd = (op == OP_READ);

    // ---------------------------------------------------------------
    // Storage array
    // ---------------------------------------------------------------
`ifdef RAM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[addr] <= data;
        end
    end
`else
    // No reset on the array: contents survive rst, only the write is
    // suppressed in a reset cycle.
    always_ff @(posedge clk) begin
        if (do_wr && !rst) begin
            mem[addr] <= data;
        end
    end
`endif

    // ---------------------------------------------------------------
    // Read register: captures on a read edge, holds otherwise. rd_vld
    // only lives for the cycle after a read edge.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= '0;
            rd_vld <= 1'b0;
        end else if (do_rd) begin
            rd_q   <= mem[addr];
            rd_vld <= 1'b1;
        end else begin
            rd_vld <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Bus drive. Gated by the live enable/we so the bus is released
    // combinationally; a write cycle can never collide with our drive.
    // ---------------------------------------------------------------
    assign bus_oe = rd_vld && enable && !we;
    assign data   = bus_oe ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_16x8.sv
// Self-checking bench for ram_16x8.
// Stimulus issues one operation per clock; for every cycle the value the bus
// must show in that cycle is pushed to a queue, and a monitor on the falling
// edge pops and compares. The reference model is a plain array plus "last
// edge was a read of value X" state. The bus carries pull-ups, so a released
// bus reads as 8'hFF; random write data is kept below 8'hFF so a released bus
// is always distinguishable from a driven word.

module tb_ram_16x8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] host_d = '0;
    wire  [7:0] data;

    int checks = 0;
    int errors = 0;

    assign data = we ? host_d : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (data[g]);
    end

    ram_16x8 #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .we     (we),
        .enable (enable),
        .addr   (addr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] ref_mem   [16];
    bit         ref_known [16];
    bit         prev_vld   = 1'b0;   // last edge performed a read
    bit         prev_known = 1'b0;   // value read at that edge is defined
    bit         vld_known  = 1'b0;   // false until the first reset
    logic [7:0] prev_val   = '0;

    // bit 8 = compare this cycle, bits 7:0 = expected bus value
    logic [8:0] exp_q [$];
    int         cyc = 0;

    // Apply the effect of the clock edge that just occurred, using the
    // inputs the bench was holding across it.
    task automatic model_edge();
        if (rst) begin
            prev_vld  = 1'b0;
            vld_known = 1'b1;
`ifdef RAM_CLEAR_ON_RESET_EN
            for (int i = 0; i < 16; i++) begin
                ref_mem[i]   = 8'h00;
                ref_known[i] = 1'b1;
            end
`endif
        end else if (we && !enable) begin
            ref_mem[addr]   = host_d;
            ref_known[addr] = 1'b1;
            prev_vld        = 1'b0;
        end else if (!we && enable) begin
            prev_val   = ref_mem[addr];
            prev_known = ref_known[addr];
            prev_vld   = 1'b1;
        end else begin
            prev_vld = 1'b0;
        end
    endtask

    // Expected bus value for the inputs now being driven.
    function automatic logic [8:0] bus_expect();
        if (we)                               return {1'b1, host_d};
        if (!enable)                          return {1'b1, 8'hFF};
        if (!vld_known)                       return 9'h000;
        if (!prev_vld)                        return {1'b1, 8'hFF};
        if (!prev_known)                      return 9'h000;
        return {1'b1, prev_val};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // One bus cycle: wait for the edge, account for it, drive the new
    // operation and queue what the bus must show during it.
    task automatic op(input bit r, input bit w, input bit e, input logic [3:0] a,
                      input logic [7:0] d);
        @(posedge clk);
        model_edge();
        #1;
        rst = r; we = w; enable = e; addr = a; host_d = d;
        cyc++;
        exp_q.push_back(bus_expect());
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if (e[8]) check("bus", data, e[7:0]);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b0;
        end

        // reset then idle
        op(1, 0, 0, 4'd0, 8'h00);
        op(1, 0, 0, 4'd0, 8'h00);
        op(0, 0, 0, 4'd0, 8'h00);

        // sequential fill, idle, readback (one extra read flushes word 15)
        for (int i = 0; i < 16; i++) op(0, 1, 0, 4'(i), 8'(i));
        op(0, 0, 0, 4'd0, 8'h00);
        for (int i = 0; i < 16; i++) op(0, 0, 1, 4'(i), 8'h00);
        op(0, 0, 1, 4'd0, 8'h00);
        op(0, 0, 0, 4'd0, 8'h00);

        // pattern and overwrite
        op(0, 1, 0, 4'd5, 8'hA5);
        op(0, 1, 0, 4'd5, 8'h3C);
        op(0, 0, 1, 4'd5, 8'h00);
        op(0, 0, 1, 4'd4, 8'h00);
        op(0, 0, 1, 4'd4, 8'h00);
        op(0, 0, 0, 4'd0, 8'h00);

        // illegal mode must neither write nor drive
        op(0, 1, 1, 4'd2, 8'hFF);
        op(0, 0, 1, 4'd2, 8'h00);
        op(0, 0, 1, 4'd2, 8'h00);
        op(0, 0, 0, 4'd0, 8'h00);

        // reset on the addr-8 read edge
        op(0, 0, 1, 4'd7, 8'h00);
        op(1, 0, 1, 4'd8, 8'h00);
        op(0, 0, 1, 4'd9, 8'h00);
        op(0, 0, 1, 4'd9, 8'h00);
        op(0, 0, 0, 4'd0, 8'h00);

        // restore known contents for the release test
        op(0, 1, 0, 4'd3, 8'h33);
        op(0, 1, 0, 4'd4, 8'h44);

        // bus release: drop enable mid-cycle while mem[3] is on the bus
        op(0, 0, 1, 4'd3, 8'h00);
        op(0, 0, 1, 4'd4, 8'h00);
        @(negedge clk);
        #2;
        enable = 1'b0;
        #1;
        check("release", data, 8'hFF);
        // next cycle idle; reassert enable mid-cycle, bus must stay off
        op(0, 0, 0, 4'd4, 8'h00);
        @(negedge clk);
        #2;
        enable = 1'b1;
        #1;
        check("reassert", data, 8'hFF);
        // the edge now captures a read of addr 4; data appears after it
        op(0, 0, 1, 4'd4, 8'h00);
        op(0, 0, 0, 4'd0, 8'h00);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            bit r;
            bit [1:0] m;
            r = ($urandom_range(19, 0) == 0);
            m = 2'($urandom_range(3, 0));
            op(r, m[1], m[0], 4'($urandom_range(15, 0)), 8'($urandom_range(254, 0)));
        end
        op(0, 0, 0, 4'd0, 8'h00);

        @(negedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_16x8.md
Name: ram_16x8

Overview:
- Single-port synchronous RAM, 16 words x 8 bits, with one bidirectional data bus.
- The host drives the bus for writes. The RAM drives the bus for reads and tri-states it otherwise.
- Used as a small scratch memory on a shared tri-state data bus in the clk domain.

Parameters:
- ADDR_WIDTH, 4, address bits; depth = 2**ADDR_WIDTH (16).
- DATA_WIDTH, 8, word and data-bus width.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- data  inout  DATA_WIDTH  bidirectional data bus; host drives it on writes, RAM drives it on reads, high-Z otherwise.
- we  input  1  write enable, active high.
- enable  input  1  read (output) enable, active high.
- addr  input  ADDR_WIDTH  word address.

Behaviour:
- Interface (already decided): one clock (clk); reset rst is synchronous and active-high.
- Operation is decoded from {we, enable} at every rising clk edge:
  - 10 = write
  - 01 = read
  - 00 = idle
  - 11 = illegal; treated as idle: no write, no bus drive, array and read register unchanged.
- Write:
  - At a rising edge with we=1, enable=0, rst=0: mem[addr] <= data.
  - Zero latency to the array; the word is readable from the next cycle.
  - The RAM never drives the bus while we=1.
- Read:
  - At a rising edge with we=0, enable=1, rst=0: rd_q <= mem[addr] and rd_vld <= 1.
  - In any other mode: rd_vld <= 0 and rd_q holds its value.
  - Read latency is 1 cycle. Data addressed in cycle N appears on the bus after edge N+1.
- Bus drive:
  - data = rd_q when (rd_vld && enable && !we); otherwise all bits Z.
  - Drive is gated combinationally by the current enable/we, so the bus releases immediately when enable falls or we rises.
- Back-to-back:
  - Consecutive read cycles stream one word per cycle.
  - A write followed by a read of the same address returns the new data.
  - A read issued in the same cycle as a write is impossible because the modes are mutually exclusive.
- Address: full decode; all 16 addresses valid, so there is no out-of-range case.
- Reset:
  - At a rising edge with rst=1: rd_vld <= 0 and rd_q <= 0, so the bus goes Z.
  - Reset overrides write and read in the same cycle.
  - Array contents on reset: see Optional Feature.
- Power-up, before the first reset: array contents undefined; bus Z once rd_vld is cleared.

Optional Feature:
- Macro: RAM_CLEAR_ON_RESET_EN.
- Defined: a synchronous reset also clears every array word to 0 in the reset cycle. A read after reset returns 8'h00 at every address.
- Undefined: reset affects only rd_q and rd_vld. Array contents are preserved across reset, so the array may map to plain block/distributed RAM.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then we=0, enable=0 -> data is Z; rd_vld=0.
- Sequential fill and readback:
  - Write mem[i]=i for i=0..15, one per cycle (we=1, enable=0, host drives data).
  - Then idle 1 cycle, then read addr 0..15 one per cycle.
  - Required: data equals 8'h00..8'h0F, each one cycle after its address; Z during the idle cycle.
- Pattern and overwrite:
  - Write addr 5=8'hA5, then addr 5=8'h3C, then read addr 5 -> 8'h3C.
  - Read addr 4 (previously 8'h04) -> unchanged.
- Illegal mode:
  - Drive we=1, enable=1 with addr 2, host data 8'hFF.
  - Required: data not driven by RAM; a later read of addr 2 returns the prior value 8'h02.
- Reset mid-read:
  - Stream reads of addr 7,8,9 and assert rst on the addr-8 edge.
  - Required: bus Z after that edge; with RAM_CLEAR_ON_RESET_EN a subsequent read of addr 9 returns 8'h00, without it 8'h09.
- Bus release:
  - During a read stream, drop enable mid-cycle -> data goes Z immediately (no clock edge needed).
  - Reassert enable -> bus stays Z until the next edge, then data = mem[addr].
